// File: rtl/rom_access_arbiter_if.sv
// Signal bundle between the core fetch/load units, rom_access_arbiter and rom_controller.
// slave = arbiter side, master = requesters plus the ROM controller driving the arbiter.
`timescale 1ns/1ps
interface rom_access_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_rdata;
    logic              rom_ready;

    logic              bist_start;
    logic              mbist_en;
    logic              mbist_done;
    logic              mbist_fail;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_fail;
    logic              bist_timeout;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, rom_rdata, rom_ready,
               bist_start, mbist_done, mbist_fail,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               rom_req, rom_addr, mbist_en, bist_busy, bist_done, bist_fail, bist_timeout
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, rom_rdata, rom_ready,
               bist_start, mbist_done, mbist_fail,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               rom_req, rom_addr, mbist_en, bist_busy, bist_done, bist_fail, bist_timeout
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// IF/D ROM port arbiter (round-robin; fixed IF priority with ROM_ARB_FIXED_PRIO_EN) plus MBIST sequencer.
// Grant is same-cycle, data returns 1 cycle later at 1 read/cycle; requests stall with gnt=0 during MBIST.
`timescale 1ns/1ps
module rom_access_arbiter #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 32,
    parameter int MBIST_TIMEOUT = 20000
) (
    input  logic                clk,
    input  logic                rst_n,
    rom_access_arbiter_if.slave bus
);
    localparam int TMR_W = $clog2(MBIST_TIMEOUT + 1);

    typedef enum logic [1:0] {ARB, DRAIN, BIST_RUN, BIST_EXIT} state_t;

    state_t            state;
    logic              outstanding;
    logic              owner_if;
    logic              owner_d;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;
    logic              timer_hit;
    logic              mbist_en_q;
    logic              busy_q;
    logic              done_q;
    logic              fail_q;
    logic              timeout_q;
    logic              can_grant;
    logic              gnt_if;
    logic              gnt_d;
    logic              grant;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] rdata;

`ifndef ROM_ARB_FIXED_PRIO_EN
    logic              prefer_d;
`endif

    // A returning read frees the port in the same cycle, so grants can be back-to-back.
    always_comb begin
        can_grant = (state == ARB) && !bus.bist_start && (!outstanding || bus.rom_ready);
`ifdef ROM_ARB_FIXED_PRIO_EN
        gnt_if = can_grant && bus.if_req;
        gnt_d  = can_grant && bus.d_req && !bus.if_req;
`else
        gnt_if = can_grant && bus.if_req && !(bus.d_req && prefer_d);
        gnt_d  = can_grant && bus.d_req && !(bus.if_req && !prefer_d);
`endif
    end

    assign grant      = gnt_if | gnt_d;
    assign grant_addr = gnt_d ? bus.d_addr : (gnt_if ? bus.if_addr : '0);
    assign rdata      = bus.rom_rdata;
    assign timer_nxt  = timer + 1'b1;
    assign timer_hit  = (timer_nxt == TMR_W'(MBIST_TIMEOUT));

    assign bus.if_gnt       = gnt_if;
    assign bus.d_gnt        = gnt_d;
    assign bus.rom_req      = grant;
    assign bus.rom_addr     = grant_addr;
    assign bus.if_rvalid    = bus.rom_ready & outstanding & owner_if;
    assign bus.d_rvalid     = bus.rom_ready & outstanding & owner_d;
    assign bus.if_rdata     = rdata;
    assign bus.d_rdata      = rdata;
    assign bus.mbist_en     = mbist_en_q;
    assign bus.bist_busy    = busy_q;
    assign bus.bist_done    = done_q;
    assign bus.bist_fail    = fail_q;
    assign bus.bist_timeout = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            outstanding <= 1'b0;
            owner_if    <= 1'b0;
            owner_d     <= 1'b0;
            timer       <= '0;
            mbist_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            prefer_d    <= 1'b0;
`endif
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
                owner_if    <= gnt_if;
                owner_d     <= gnt_d;
            end else if (bus.rom_ready) begin
                outstanding <= 1'b0;
            end
`ifndef ROM_ARB_FIXED_PRIO_EN
            if (grant) begin
                prefer_d <= gnt_if;
            end
`endif
            case (state)
                ARB: begin
                    if (bus.bist_start) begin
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        fail_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!outstanding || bus.rom_ready) begin
                        mbist_en_q <= 1'b1;
                        timer      <= '0;
                        state      <= BIST_RUN;
                    end
                end
                BIST_RUN: begin
                    timer <= timer_nxt;
                    // A completion landing on the last allowed cycle is a real result, not a timeout.
                    if (bus.mbist_done) begin
                        fail_q     <= bus.mbist_fail;
                        done_q     <= 1'b1;
                        mbist_en_q <= 1'b0;
                        state      <= BIST_EXIT;
                    end else if (timer_hit) begin
                        timeout_q  <= 1'b1;
                        fail_q     <= 1'b1;
                        done_q     <= 1'b1;
                        mbist_en_q <= 1'b0;
                        state      <= BIST_EXIT;
                    end
                end
                BIST_EXIT: begin
                    busy_q <= 1'b0;
                    state  <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Randomized + directed bench for rom_access_arbiter with a ROM/MBIST environment model,
// a cycle-level reference model of grants and BIST timeline, and a response scoreboard.
`timescale 1ns/1ps
module tb_rom_access_arbiter;
    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rom_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    rom_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MBIST_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Environment: ROM word i = DEAD0000+i, answered one cycle after rom_req.
    logic spur     = 1'b0;
    int   bist_lat = 10;    // cycles of mbist_en until mbist_done; 0 = never
    logic fail_val = 1'b0;
    int   run_cnt  = 0;

    always @(posedge clk) begin
        bus.rom_ready <= bus.rom_req | spur;
        bus.rom_rdata <= 32'hDEAD0000 + 32'(bus.rom_addr >> 2);
        run_cnt       <= bus.mbist_en ? run_cnt + 1 : 0;
    end
    assign bus.mbist_done = bus.mbist_en && (bist_lat != 0) && (run_cnt == bist_lat - 1);
    assign bus.mbist_fail = fail_val;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    // Reference model state: who was granted last, and the BIST timeline as cycle numbers.
    bit last_d = 1'b1;
    bit m_have = 1'b0;
    int m_acc  = 0;
    int m_exit = 0;
    bit m_tmo, m_fail;
    bit o_done, o_fail, o_tmo;
    bit seen_if_gnt, seen_d_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        #2;
        cyc++;
        if (!rst_n) begin
            last_d = 1'b1; m_have = 1'b0;
            o_done = 1'b0; o_fail = 1'b0; o_tmo = 1'b0;
            seen_if_gnt = 1'b0; seen_d_gnt = 1'b0;
            sbq.delete();
        end else begin
            bit   busy_e, en_e, done_e, fail_e, tmo_e, arb, eg_if, eg_d;
            int   r;
            exp_t e;
            busy_e = m_have && cyc > m_acc && cyc <= m_exit;
            en_e   = m_have && cyc >= m_acc + 2 && cyc < m_exit;
            if (m_have && cyc >= m_exit)     {done_e, fail_e, tmo_e} = {1'b1, m_fail, m_tmo};
            else if (m_have && cyc > m_acc)  {done_e, fail_e, tmo_e} = 3'b000;
            else                             {done_e, fail_e, tmo_e} = {o_done, o_fail, o_tmo};
            arb = !m_have || cyc > m_exit;
            eg_if = 1'b0;
            eg_d  = 1'b0;
            if (arb && bus.bist_start) begin
                {o_done, o_fail, o_tmo} = {done_e, fail_e, tmo_e};
                m_tmo  = (bist_lat == 0) || (bist_lat > TMO);
                r      = m_tmo ? TMO : bist_lat;
                m_fail = m_tmo ? 1'b1 : fail_val;
                m_acc  = cyc;
                m_exit = cyc + 2 + r;
                m_have = 1'b1;
            end else if (arb) begin
                if (bus.if_req && bus.d_req) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
                    eg_if = 1'b1;
`else
                    eg_if = last_d;
                    eg_d  = !last_d;
`endif
                end else begin
                    eg_if = bus.if_req;
                    eg_d  = bus.d_req;
                end
                if (eg_if || eg_d) begin
                    last_d = eg_d;
                    e.is_d = eg_d;
                    e.data = 32'hDEAD0000 + 32'((eg_d ? bus.d_addr : bus.if_addr) >> 2);
                    e.due  = cyc + 1;
                    sbq.push_back(e);
                    chk("rom_addr", 32'(bus.rom_addr), 32'(eg_d ? bus.d_addr : bus.if_addr));
                end
            end
            chk("if_gnt", bus.if_gnt, eg_if);
            chk("d_gnt", bus.d_gnt, eg_d);
            chk("rom_req", bus.rom_req, eg_if | eg_d);
            chk("mbist_en", bus.mbist_en, en_e);
            chk("bist_busy", bus.bist_busy, busy_e);
            chk("bist_done", bus.bist_done, done_e);
            chk("bist_fail", bus.bist_fail, fail_e);
            chk("bist_timeout", bus.bist_timeout, tmo_e);
            seen_if_gnt = bus.if_gnt;
            seen_d_gnt  = bus.d_gnt;
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            exp_t e;
            if (bus.if_rvalid || bus.d_rvalid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected if_rvalid=%b d_rvalid=%b required=0/0 cycle=%0d",
                             bus.if_rvalid, bus.d_rvalid, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("if_rvalid", bus.if_rvalid, !e.is_d);
                    chk("d_rvalid", bus.d_rvalid, e.is_d);
                    chk("rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.data);
                    chk("resp_cycle", cyc, e.due);
                end
            end else begin
                chk("resp_missing", (sbq.size() != 0 && sbq[0].due <= cyc), 1'b0);
                if (sbq.size() != 0 && sbq[0].due <= cyc) e = sbq.pop_front();
            end
        end
    end

    task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit dr,
                         input logic [AW-1:0] da, input bit bs);
        @(negedge clk);
        bus.if_req = ir; bus.if_addr = ia;
        bus.d_req  = dr; bus.d_addr  = da;
        bus.bist_start = bs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic drive_rand(input int n, input int bist_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!bus.if_req || seen_if_gnt) begin
                bus.if_req  = ($urandom_range(99) < 60);
                bus.if_addr = AW'($urandom_range(32'h7FFF));
            end
            if (!bus.d_req || seen_d_gnt) begin
                bus.d_req  = ($urandom_range(99) < 60);
                bus.d_addr = AW'($urandom_range(32'h7FFF));
            end
            bus.bist_start = 1'b0;
            if ($urandom_range(99) < bist_pct) begin
                if (!m_have || cyc >= m_exit) begin
                    case ($urandom_range(3))
                        0:       bist_lat = 0;
                        1:       bist_lat = $urandom_range(10, 1);
                        2:       bist_lat = TMO;
                        default: bist_lat = TMO + 1;
                    endcase
                    fail_val = 1'($urandom_range(1));
                end
                bus.bist_start = 1'b1;
            end
        end
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_addr  = '0;
        bus.bist_start = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_if_gnt", bus.if_gnt, 1'b0);
        chk("rst_rom_req", bus.rom_req, 1'b0);
        chk("rst_mbist_en", bus.mbist_en, 1'b0);
        chk("rst_bist_busy", bus.bist_busy, 1'b0);
        chk("rst_bist_done", bus.bist_done, 1'b0);
        chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 15'h0010, 1'b0, '0, 1'b0);
        idle(2);
        repeat (8) drive(1'b1, 15'h0000, 1'b1, 15'h0020, 1'b0);
        idle(2);

        bist_lat = 10; fail_val = 1'b0;
        drive(1'b0, '0, 1'b1, 15'h0020, 1'b0);
        drive(1'b1, 15'h0004, 1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++) drive(1'b1, 15'h0004, 1'b0, '0, (i == 6));
        idle(2);

        bist_lat = 5; fail_val = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        idle(10);

        bist_lat = 0;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        idle(56);

        bist_lat = TMO; fail_val = 1'b0;
        drive(1'b0, '0, 1'b1, 15'h0100, 1'b1);
        idle(56);

        spur = 1'b1;
        idle(1);
        spur = 1'b0;
        idle(3);

        bist_lat = 0;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        idle(10);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mbist_en", bus.mbist_en, 1'b0);
        chk("arst_bist_busy", bus.bist_busy, 1'b0);
        chk("arst_bist_done", bus.bist_done, 1'b0);
        chk("arst_bist_fail", bus.bist_fail, 1'b0);
        chk("arst_bist_timeout", bus.bist_timeout, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 15'h0004, 1'b0, '0, 1'b0);
        idle(3);

        drive_rand(600, 2);
        idle(60);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares the single ROM controller port between an instruction-fetch requester (IF) and a data-load requester (D).
- Also sequences ROM MBIST. On request it drains outstanding reads, runs MBIST with a timeout watchdog, reports the result, then returns the ROM to normal service.
- Sits between the core fetch/load units and rom_controller.

Parameters:
- ADDR_W, 15, byte address width to the ROM.
- DATA_W, 32, read data width.
- MBIST_TIMEOUT, 20000, maximum cycles mbist_en is held before a timeout is declared (counter width = $clog2(MBIST_TIMEOUT+1)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- if_req  in  1  IF read request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  IF byte address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DATA_W  IF read data.
- d_req  in  1  D read request; held with d_addr until d_gnt.
- d_addr  in  ADDR_W  D byte address.
- d_gnt  out  1  D request accepted this cycle.
- d_rvalid  out  1  d_rdata valid.
- d_rdata  out  DATA_W  D read data.
- rom_req  out  1  to rom_controller.
- rom_addr  out  ADDR_W  to rom_controller.
- rom_rdata  in  DATA_W  from rom_controller.
- rom_ready  in  1  from rom_controller; asserted 1 cycle after rom_req.
- bist_start  in  1  single-cycle pulse requesting an MBIST run.
- mbist_en  out  1  to rom_controller.
- mbist_done  in  1  from rom_controller.
- mbist_fail  in  1  from rom_controller.
- bist_busy  out  1  high from accepted bist_start until return to ARB.
- bist_done  out  1  sticky; set at MBIST completion or timeout; cleared by next accepted bist_start.
- bist_fail  out  1  sticky; captured mbist_fail, or 1 on timeout.
- bist_timeout  out  1  sticky; timeout occurred.

Behaviour:
- Reset: all outputs 0; state ARB; round-robin pointer favours IF; owner register clear; timer 0.
- States: ARB, DRAIN, BIST_RUN, BIST_EXIT.
- ARB:
  - A grant may issue when no read is outstanding, or when rom_ready returns this cycle, giving back-to-back throughput of 1 read/cycle.
  - On grant: rom_req=1, rom_addr=winner's addr, winner's gnt=1, all combinational in the same cycle.
  - Owner register and outstanding flag are set at the clock edge.
- Arbitration:
  - Round-robin; when both request, the requester not granted last wins.
  - A single requester always wins.
  - The pointer updates only on a grant.
- Response:
  - {if,d}_rvalid = rom_ready & (owner==IF / D).
  - Both rdata ports = rom_rdata, pass-through; data is meaningful only with rvalid.
  - The outstanding flag clears on rom_ready unless a new grant occurs in the same cycle.
- bist_start in ARB:
  - Takes priority over requests in that cycle: no grant.
  - Sets bist_busy=1 and clears bist_done, bist_fail and bist_timeout.
  - Goes to DRAIN.
- bist_start outside ARB is ignored.
- DRAIN: no grants. When outstanding=0 (or rom_ready arrives), goes to BIST_RUN next cycle.
- BIST_RUN:
  - mbist_en=1 (registered); timer increments each cycle.
  - mbist_done=1: bist_fail<=mbist_fail, bist_done<=1, go to BIST_EXIT.
  - Timer reaches MBIST_TIMEOUT without mbist_done: bist_timeout<=1, bist_fail<=1, bist_done<=1, go to BIST_EXIT.
  - mbist_done and timeout in the same cycle: mbist_done wins, so no timeout is flagged.
- BIST_EXIT: mbist_en=0 for one cycle (the rom_controller returns to idle), no grants; then ARB with bist_busy=0.
- Requests during DRAIN, BIST_RUN and BIST_EXIT stall with gnt=0; requesters hold req/addr.
- rom_ready with no outstanding read is ignored: no rvalid.
- Asynchronous reset mid-BIST: mbist_en drops immediately, status clears, state returns to ARB.

Optional Feature:
- ROM_ARB_FIXED_PRIO_EN defined: fixed priority, IF always beats D; the round-robin pointer is removed.
- Undefined: round-robin as above.

Test Plan:
- ROM preloaded with word i = 0xDEAD0000+i. IF alone reads addr 0x0010 -> if_gnt in the request cycle; next cycle if_rvalid=1, if_rdata=0xDEAD0004; d_rvalid=0.
- IF and D both held continuously, if_addr=0x0000, d_addr=0x0020 -> grants alternate IF, D, IF, D on consecutive cycles. Responses arrive 1 cycle after each grant (0xDEAD0000 / 0xDEAD0008) with no dead cycles. With ROM_ARB_FIXED_PRIO_EN, only IF is granted.
- bist_start in the same cycle a D read returns -> no new grant; DRAIN, then mbist_en rises. A healthy ROM gives mbist_done -> bist_done=1, bist_fail=0, bist_timeout=0; mbist_en low 1 cycle before the first new grant.
- if_req held throughout MBIST -> if_gnt=0 the whole time. After BIST_EXIT, if_addr 0x0004 returns 0xDEAD0001.
- MBIST_TIMEOUT=50, mbist_done forced low -> after 50 BIST_RUN cycles: bist_timeout=1, bist_fail=1, bist_done=1, mbist_en=0, bist_busy drops 1 cycle later.
- rst_n pulsed low mid-BIST_RUN -> mbist_en, bist_busy and all status outputs 0 immediately, without waiting for a clock. After reset release, a normal read completes correctly.
